// File: rtl/axi4lite_reg_slave.sv
// AXI4-Lite register bank: R registers of N bytes, byte strobes, read-only status slots, SLVERR decode.
// Define AXI4LITE_REG_WPULSE_EN to add the per-register WrPulse commit strobe output.
module axi4lite_reg_slave #(
  parameter int N = 4,
  parameter int A = 12,
  parameter int R = 16,
  parameter logic [R-1:0] RO_MASK = '0,
  parameter logic [8*N-1:0] RESET_VAL = '0
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic [A-1:0]      AWADDR,
  input  logic [2:0]        AWPROT,
  input  logic              AWVALID,
  output logic              AWREADY,
  input  logic [8*N-1:0]    WDATA,
  input  logic [N-1:0]      WSTRB,
  input  logic              WVALID,
  output logic              WREADY,
  output logic [1:0]        BRESP,
  output logic              BVALID,
  input  logic              BREADY,
  input  logic [A-1:0]      ARADDR,
  input  logic [2:0]        ARPROT,
  input  logic              ARVALID,
  output logic              ARREADY,
  output logic [8*N-1:0]    RDATA,
  output logic [1:0]        RRESP,
  output logic              RVALID,
  input  logic              RREADY,
  output logic [R*8*N-1:0]  RegOut,
  input  logic [R*8*N-1:0]  StatusIn
`ifdef AXI4LITE_REG_WPULSE_EN
  ,
  output logic [R-1:0]      WrPulse
`endif
);

  localparam int DW = 8 * N;
  localparam int IW = $clog2(R);
  localparam int BW = $clog2(N);
  localparam logic [A:0] LIMIT = (A+1)'(R * N);
  localparam logic [1:0] RESP_OKAY = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  logic [DW-1:0] regs_q [R];

  logic          aw_full_q, aw_full_d;
  logic          w_full_q, w_full_d;
  logic [A-1:0]  aw_addr_q;
  logic [DW-1:0] w_data_q;
  logic [N-1:0]  w_strb_q;
  logic          aw_ready_q, w_ready_q, ar_ready_q;
  logic          bvalid_q, bvalid_d;
  logic [1:0]    bresp_q;
  logic          rvalid_q, rvalid_d;
  logic [1:0]    rresp_q;
  logic [DW-1:0] rdata_q;

  logic          aw_hs, w_hs, ar_hs, commit, wr_ok;
  logic [IW-1:0] wr_idx, rd_idx;
  logic          rd_in_range;
  logic [DW-1:0] rd_word;

  logic unused_prot;
  assign unused_prot = ^{AWPROT, ARPROT};

  always_comb begin
    aw_hs       = AWVALID && aw_ready_q;
    w_hs        = WVALID && w_ready_q;
    ar_hs       = ARVALID && ar_ready_q;
    commit      = aw_full_q && w_full_q;
    wr_idx      = aw_addr_q[BW +: IW];
    wr_ok       = ({1'b0, aw_addr_q} < LIMIT) && !RO_MASK[wr_idx];
    rd_idx      = ARADDR[BW +: IW];
    rd_in_range = ({1'b0, ARADDR} < LIMIT);
    rd_word     = '0;
    if (rd_in_range) begin
      if (RO_MASK[rd_idx]) rd_word = StatusIn[int'(rd_idx) * DW +: DW];
      else                 rd_word = regs_q[rd_idx];
    end
    aw_full_d = commit ? 1'b0 : (aw_full_q || aw_hs);
    w_full_d  = commit ? 1'b0 : (w_full_q || w_hs);
    bvalid_d  = commit ? 1'b1 : (bvalid_q && !BREADY);
    rvalid_d  = ar_hs ? 1'b1 : (rvalid_q && !RREADY);
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      aw_full_q  <= 1'b0;
      w_full_q   <= 1'b0;
      aw_addr_q  <= '0;
      w_data_q   <= '0;
      w_strb_q   <= '0;
      aw_ready_q <= 1'b0;
      w_ready_q  <= 1'b0;
      ar_ready_q <= 1'b0;
      bvalid_q   <= 1'b0;
      bresp_q    <= RESP_OKAY;
      rvalid_q   <= 1'b0;
      rresp_q    <= RESP_OKAY;
      rdata_q    <= '0;
      for (int r = 0; r < R; r++) regs_q[r] <= RESET_VAL;
    end else begin
      aw_full_q  <= aw_full_d;
      w_full_q   <= w_full_d;
      bvalid_q   <= bvalid_d;
      rvalid_q   <= rvalid_d;
      // Ready is registered from next-state so a full slot or pending response blocks the very next beat.
      aw_ready_q <= !aw_full_d && !bvalid_d;
      w_ready_q  <= !w_full_d && !bvalid_d;
      ar_ready_q <= !rvalid_d;
      if (aw_hs) aw_addr_q <= AWADDR;
      if (w_hs) begin
        w_data_q <= WDATA;
        w_strb_q <= WSTRB;
      end
      if (commit) begin
        bresp_q <= wr_ok ? RESP_OKAY : RESP_SLVERR;
        if (wr_ok) begin
          for (int b = 0; b < N; b++) begin
            if (w_strb_q[b]) regs_q[wr_idx][8*b +: 8] <= w_data_q[8*b +: 8];
          end
        end
      end
      if (ar_hs) begin
        rdata_q <= rd_word;
        rresp_q <= rd_in_range ? RESP_OKAY : RESP_SLVERR;
      end
    end
  end

  assign AWREADY = aw_ready_q;
  assign WREADY  = w_ready_q;
  assign ARREADY = ar_ready_q;
  assign BVALID  = bvalid_q;
  assign BRESP   = bresp_q;
  assign RVALID  = rvalid_q;
  assign RRESP   = rresp_q;
  assign RDATA   = rdata_q;

  for (genvar r = 0; r < R; r++) begin : g_regout
    assign RegOut[r*DW +: DW] = RO_MASK[r] ? '0 : regs_q[r];
  end

`ifdef AXI4LITE_REG_WPULSE_EN
  logic [R-1:0] wpulse_q;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      wpulse_q <= '0;
    end else begin
      wpulse_q <= '0;
      if (commit && wr_ok && (|w_strb_q)) wpulse_q[wr_idx] <= 1'b1;
    end
  end

  assign WrPulse = wpulse_q;
`endif

endmodule
